// File: rtl/data_check.sv
// data_check: checks a burst stream against the ideal sequence
// FIRST_WORD, FIRST_WORD+WORD_INC, ... (all modulo 2^32). It reports a
// per-burst pass/length verdict, live and final word counts, a
// cumulative mismatch count and a snapshot of the first mismatch since
// reset or clear.
//
// Handshake: data_in is consumed on every rising edge where
// data_valid_in=1; there is no backpressure. A burst is a contiguous run
// of valid cycles, and the first low cycle after a run closes it. done_o
// is a registered one-cycle pulse that rises on the edge that sampled
// that low cycle, and a new burst may start on the very next edge.

module data_check #(
  parameter logic [31:0] FIRST_WORD = 32'h04050607,
  parameter logic [31:0] WORD_INC   = 32'h04040404,
  parameter int          ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          data_in,
  input  logic                 data_valid_in,
  input  logic [7:0]           len_in,
  input  logic                 chk_clear,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 len_err_o,
  output logic [8:0]           word_cnt_o,
  output logic [ERR_CNT_W-1:0] data_err_cnt_o,
  output logic [31:0]          first_err_data_o,
  output logic [31:0]          first_err_exp_o,
  output logic [8:0]           first_err_idx_o,
  output logic [15:0]          burst_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [8:0] WORD_CNT_MAX = 9'd511;

  // State and result registers
  state_t                state_q, state_d;
  logic [31:0]           exp_q, exp_d;            // expected value of the next RUN word
  logic [7:0]            len_q, len_d;            // len_in latched on the first word
  logic                  burst_err_q, burst_err_d; // any mismatch in the current burst
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  len_err_q, len_err_d;
  logic [8:0]            word_cnt_q, word_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  first_seen_q, first_seen_d;
  logic [31:0]           first_data_q, first_data_d;
  logic [31:0]           first_exp_q, first_exp_d;
  logic [8:0]            first_idx_q, first_idx_d;
  logic [15:0]           burst_cnt_q, burst_cnt_d;

  // Per-word compare terms, shared by both states
  logic [31:0] cmp_word;
  logic [8:0]  cmp_idx;
  logic        mismatch;
  logic        len_mismatch;

  // Select the reference word and index for the word on data_in this cycle
  always_comb begin
    cmp_word     = exp_q;
    cmp_idx      = word_cnt_q;
    if (state_q == IDLE) begin
      cmp_word = FIRST_WORD;
      cmp_idx  = 9'd0;
    end
    mismatch     = data_valid_in && (data_in != cmp_word);
    // len_q+1 spans 1..256; a saturated count of 511 never matches it
    len_mismatch = (word_cnt_q != ({1'b0, len_q} + 9'd1));
  end

  // Next-state logic: burst tracking, statistics and clear handling
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    len_d        = len_q;
    burst_err_d  = burst_err_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    len_err_d    = len_err_q;
    word_cnt_d   = word_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_seen_d = first_seen_q;
    first_data_d = first_data_q;
    first_exp_d  = first_exp_q;
    first_idx_d  = first_idx_q;
    burst_cnt_d  = burst_cnt_q;

    if (chk_clear) begin
      // Clear wins over any word on data_in: the burst is abandoned silently
      state_d      = IDLE;
      exp_d        = '0;
      len_d        = '0;
      burst_err_d  = 1'b0;
      pass_d       = 1'b0;
      len_err_d    = 1'b0;
      word_cnt_d   = '0;
      err_cnt_d    = '0;
      first_seen_d = 1'b0;
      first_data_d = '0;
      first_exp_d  = '0;
      first_idx_d  = '0;
      burst_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid_in) begin
            len_d       = len_in;
            exp_d       = FIRST_WORD + WORD_INC;
            word_cnt_d  = 9'd1;
            burst_err_d = mismatch;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (data_valid_in) begin
            // Expected follows the ideal sequence whatever arrives, so one
            // corrupt word costs exactly one error
            exp_d = exp_q + WORD_INC;
            if (word_cnt_q != WORD_CNT_MAX) begin
              word_cnt_d = word_cnt_q + 9'd1;
            end
            if (mismatch) begin
              burst_err_d = 1'b1;
            end
          end else begin
            done_d      = 1'b1;
            len_err_d   = len_mismatch;
            pass_d      = !burst_err_q && !len_mismatch;
            burst_cnt_d = burst_cnt_q + 16'd1;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Mismatch statistics apply to any accepted word in either state
      if (mismatch) begin
        if (!(&err_cnt_q)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        if (!first_seen_q) begin
          first_seen_d = 1'b1;
          first_data_d = data_in;
          first_exp_d  = cmp_word;
          first_idx_d  = cmp_idx;
        end
      end
    end
  end

  // Register all state; synchronous active-low reset overrides everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      len_q        <= '0;
      burst_err_q  <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      len_err_q    <= 1'b0;
      word_cnt_q   <= '0;
      err_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      first_data_q <= '0;
      first_exp_q  <= '0;
      first_idx_q  <= '0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      len_q        <= len_d;
      burst_err_q  <= burst_err_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      len_err_q    <= len_err_d;
      word_cnt_q   <= word_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_seen_q <= first_seen_d;
      first_data_q <= first_data_d;
      first_exp_q  <= first_exp_d;
      first_idx_q  <= first_idx_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign len_err_o        = len_err_q;
  assign word_cnt_o       = word_cnt_q;
  assign data_err_cnt_o   = err_cnt_q;
  assign first_err_data_o = first_data_q;
  assign first_err_exp_o  = first_exp_q;
  assign first_err_idx_o  = first_idx_q;
  assign burst_cnt_o      = burst_cnt_q;

endmodule
